// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared types for the byte-serial load/store sequencer: access sizes, FSM states
// and the size-to-byte-count mapping.
package lsu_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'd0,
      SZ_HALF    = 2'd1,
      SZ_WORD    = 2'd2,
      SZ_ILLEGAL = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   // Illegal sizes map to zero bytes; they never reach the memory port.
   function automatic logic [2:0] size_to_nbytes(input size_e sz);
      case (sz)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         SZ_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Bundle of request, response and byte-RAM signals around the sequencer; names carry
// the direction as seen from the sequencer (slave modport).
interface lsu_byte_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [DATA_W-1:0] req_wdata_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_we_o;
   logic [BYTE_W-1:0] mem_wdata_o;
   logic [BYTE_W-1:0] mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  rsp_ready_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output mem_addr_o, mem_we_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output rsp_ready_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  mem_addr_o, mem_we_o, mem_wdata_o
   );
endinterface

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Turns the big-endian byte accumulator into the architectural load value,
// sign- or zero-extending from the access size.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] acc_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = '0;
      case (size_i)
         SZ_BYTE: data_o = {{24{~unsigned_i & acc_i[7]}}, acc_i[7:0]};
         SZ_HALF: data_o = {{16{~unsigned_i & acc_i[15]}}, acc_i[15:0]};
         SZ_WORD: data_o = acc_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Serialises one load/store into single-byte RAM accesses (MSB at lowest address)
// and returns the extended load result over a valid/ready response.
module lsu_byte_sequencer
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   lsu_byte_sequencer_if.slave  bus
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   size_e             size_q, size_d;
   logic              uns_q, uns_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [2:0]        nbytes_q, nbytes_d;
   logic [1:0]        cnt_q, cnt_d;

   logic [1:0]        byte_idx;
   logic              last_byte;
   logic [31:0]       ext_data;

   // Byte lane counts down from the MSB while the address counts up.
   assign byte_idx  = 2'(nbytes_q - 3'd1 - {1'b0, cnt_q});
   assign last_byte = (cnt_q == 2'(nbytes_q - 3'd1));

   lsu_load_extend u_extend (
      .acc_i      (acc_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         acc_q    <= '0;
         nbytes_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         acc_q    <= acc_d;
         nbytes_q <= nbytes_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      size_d   = size_q;
      uns_d    = uns_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      acc_d    = acc_q;
      nbytes_d = nbytes_q;
      cnt_d    = cnt_q;

      bus.mem_addr_o  = '0;
      bus.mem_we_o    = 1'b0;
      bus.mem_wdata_o = '0;
      bus.rsp_valid_o = 1'b0;
      bus.rsp_err_o   = 1'b0;
      bus.rsp_rdata_o = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i) begin
               we_d     = bus.req_we_i;
               size_d   = size_e'(bus.req_size_i);
               uns_d    = bus.req_unsigned_i;
               addr_d   = bus.req_addr_i;
               wdata_d  = bus.req_wdata_i;
               nbytes_d = size_to_nbytes(size_e'(bus.req_size_i));
               cnt_d    = '0;
               acc_d    = '0;
               err_d    = (size_e'(bus.req_size_i) == SZ_ILLEGAL);
               state_d  = (size_e'(bus.req_size_i) == SZ_ILLEGAL) ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            bus.mem_addr_o = addr_q + ADDR_W'(cnt_q);
            if (we_q) begin
               bus.mem_we_o    = 1'b1;
               bus.mem_wdata_o = wdata_q[{byte_idx, 3'b000} +: BYTE_W];
            end else begin
               acc_d = {acc_q[DATA_W-BYTE_W-1:0], bus.mem_rdata_i};
            end
            cnt_d = cnt_q + 2'd1;
            if (last_byte) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_err_o   = err_q;
            bus.rsp_rdata_o = (we_q || err_q) ? '0 : DATA_W'(ext_data);
            if (bus.rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Held low while reset is asserted even though the state already reads IDLE.
   assign bus.req_ready_o = rst_ni & (state_q == S_IDLE);

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed plus random load/store transactions against a byte RAM, compared with a
// reference model built from the big-endian byte ordering and extension rules.
module tb_lsu_byte_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   txn_no = 0;

   logic [7:0] ram [0:1023];

   lsu_byte_sequencer_if #(.ADDR_W(32), .DATA_W(32), .BYTE_W(8)) bus ();

   lsu_byte_sequencer #(.ADDR_W(32), .DATA_W(32), .BYTE_W(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   // RAM aliases every 1 KiB; the model reads through the same aliasing.
   assign bus.mem_rdata_i = ram[bus.mem_addr_o[9:0]];

   always @(posedge clk) begin
      if (bus.mem_we_o) ram[bus.mem_addr_o[9:0]] <= bus.mem_wdata_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      bus.req_valid_i    = 1'($urandom_range(0, 1));
      bus.req_we_i       = 1'($urandom_range(0, 1));
      bus.req_size_i     = 2'($urandom_range(0, 3));
      bus.req_unsigned_i = 1'($urandom_range(0, 1));
      bus.req_addr_i     = $urandom;
      bus.req_wdata_i    = $urandom;
   endtask

   task automatic run_txn(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
      int          nb;
      logic        exp_err;
      logic [31:0] raw;
      logic [31:0] exp_rd;
      logic [31:0] ea;
      nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      exp_err = (sz == 2'd3);
      raw     = 32'd0;
      for (int k = 0; k < nb; k++) begin
         ea  = a + 32'(k);
         raw = (raw << 8) | 32'(ram[ea[9:0]]);
      end
      if (we || exp_err)
         exp_rd = 32'd0;
      else if (!u && nb < 4 && raw[8*nb-1])
         exp_rd = raw - (32'd1 << (8*nb));
      else
         exp_rd = raw;

      chk("idle_ready", 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = sz;
      bus.req_unsigned_i = u;
      bus.req_addr_i     = a;
      bus.req_wdata_i    = wd;
      bus.rsp_ready_i    = 1'b0;
      @(posedge clk); #1;
      scramble();
      for (int k = 0; k < nb; k++) begin
         chk("acc_addr", bus.mem_addr_o, a + 32'(k));
         chk("acc_we", 32'(bus.mem_we_o), 32'(we));
         if (we) chk("acc_wdata", 32'(bus.mem_wdata_o), (wd >> (8*(nb-1-k))) & 32'hFF);
         chk("acc_busy", {bus.req_ready_o, bus.rsp_valid_o}, 32'd0);
         @(posedge clk); #1;
         scramble();
      end
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
      chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
      chk("rsp_mem_idle", {bus.mem_we_o, bus.mem_addr_o[30:0]}, 32'd0);
      chk("rsp_not_ready", 32'(bus.req_ready_o), 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         scramble();
         chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
         chk("hold_rdata", bus.rsp_rdata_o, exp_rd);
         chk("hold_err", 32'(bus.rsp_err_o), 32'(exp_err));
      end
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 1'b0;
      chk("post_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("post_ready", 32'(bus.req_ready_o), 32'd1);
      if (we) begin
         for (int k = 0; k < nb; k++) begin
            ea = a + 32'(k);
            chk("ram_byte", 32'(ram[ea[9:0]]), (wd >> (8*(nb-1-k))) & 32'hFF);
         end
      end
      txn_no++;
      $display("txn %0d: we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d (errors so far %0d)",
               txn_no, we, sz, u, a, wd, exp_rd, exp_err, errors);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h12; ram[10'h101] = 8'h34; ram[10'h102] = 8'h56; ram[10'h103] = 8'h78;
      ram[10'h020] = 8'h80; ram[10'h021] = 8'h81; ram[10'h022] = 8'h02;
      ram[10'h3FE] = 8'hA1; ram[10'h3FF] = 8'hB2; ram[10'h000] = 8'hC3; ram[10'h001] = 8'hD4;
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_size_i     = 2'd0;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 32'd0;
      bus.req_wdata_i    = 32'd0;
      bus.rsp_ready_i    = 1'b0;

      #2;
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_rsp", {bus.rsp_valid_o, bus.rsp_err_o}, 32'd0);
      chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
      chk("rst_mem", {bus.mem_we_o, bus.mem_wdata_o}, 32'd0);
      chk("rst_addr", bus.mem_addr_o, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;

      run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0);
      chk("lw_value", 32'h1234_5678, 32'(ram[10'h100]) << 24 | 32'(ram[10'h101]) << 16 |
                                     32'(ram[10'h102]) << 8 | 32'(ram[10'h103]));
      run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'd0, 1);
      run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'd0, 0);
      run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'd0, 0);
      run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 0);
      run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0043, 32'h1234_CAFE, 2);
      chk("sw_sh_0x42", 32'(ram[10'h042]), 32'hBE);
      chk("sh_0x43", 32'(ram[10'h043]), 32'hCA);
      chk("sh_0x44", 32'(ram[10'h044]), 32'hFE);
      run_txn(1'b1, 2'd3, 1'b0, 32'h0000_0050, 32'h5555_AAAA, 3);
      chk("illegal_no_write", 32'(ram[10'h050]), 32'h00);
      run_txn(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'd0, 0);

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, int'($urandom_range(0, 2)));
      end

      // Store interrupted by reset during its third byte cycle.
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = 1'b1;
      bus.req_size_i     = 2'd2;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i     = 32'h0000_0080;
      bus.req_wdata_i    = 32'h1122_3344;
      for (int i = 0; i < 4; i++) ram[10'h080 + 10'(i)] = 8'h00;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_we", 32'(bus.mem_we_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_we", 32'(bus.mem_we_o), 32'd0);
      chk("async_rst_addr", bus.mem_addr_o, 32'd0);
      chk("async_rst_wdata", 32'(bus.mem_wdata_o), 32'd0);
      chk("async_rst_ready", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(bus.req_ready_o), 32'd1);
      chk("abort_b0", 32'(ram[10'h080]), 32'h11);
      chk("abort_b1", 32'(ram[10'h081]), 32'h22);
      chk("abort_b2", 32'(ram[10'h082]), 32'h00);
      chk("abort_b3", 32'(ram[10'h083]), 32'h00);
      run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0080, 32'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store sequencer between the CPU execute stage and the byte-wide data RAM.
- Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request over a valid/ready handshake.
- Issues the request to memory as consecutive single-byte accesses, one byte per cycle, big-endian (lowest address holds the most significant byte).
- Returns a sign- or zero-extended 32-bit load result over a valid/ready response handshake.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, request/response data width
BYTE_W, 8, memory port data width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready at a rising edge
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
req_addr_i  input  ADDR_W  byte address (misalignment allowed)
req_wdata_i  input  DATA_W  store data, low-order bytes used
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready at a rising edge
rsp_rdata_o  output  DATA_W  extended load data (0 for stores and errors)
rsp_err_o  output  1  illegal size flagged
mem_addr_o  output  ADDR_W  byte address to RAM
mem_we_o  output  1  byte write enable
mem_wdata_o  output  BYTE_W  byte write data
mem_rdata_i  input  BYTE_W  combinational byte read data for mem_addr_o

Behaviour:
- Reset (async, rst_ni low): state IDLE. All outputs 0 (req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_addr_o, mem_we_o, mem_wdata_o). All internal registers cleared. Any in-flight operation is abandoned; no partial write completes after reset is asserted.
- States:
  - IDLE:
    - req_ready_o=1.
    - On accept, latch we, size, unsigned, addr and wdata.
    - Set nbytes = 1/2/4 and cnt=0.
    - Clear the accumulator.
    - Size 3 -> RESP with err=1; otherwise -> ACCESS.
  - ACCESS:
    - req_ready_o=0.
    - mem_addr_o = addr + cnt (mod 2^32; 0xFFFFFFFF+1 wraps to 0).
    - Store: mem_we_o=1, mem_wdata_o = wdata[8*(nbytes-1-cnt) +: 8], so the MSB is written first at the lowest address.
    - Load: mem_we_o=0; at the edge, acc <= {acc[23:0], mem_rdata_i}.
    - cnt increments each cycle; when cnt==nbytes-1, go to RESP.
  - RESP:
    - rsp_valid_o=1, held stable until rsp_ready_i.
    - Load result: byte -> bit 7 extended; half -> bit 15 extended; word -> acc as is. unsigned=1 zero-fills instead.
    - Store response: rsp_rdata_o=0.
    - On handshake -> IDLE.
- Outside ACCESS, mem_we_o=0 and mem_addr_o/mem_wdata_o=0.
- Latency: accept at edge N; bytes on cycles N+1..N+nbytes; rsp_valid_o from cycle N+nbytes+1. Illegal size gives rsp_valid_o at N+1.
- Throughput:
  - No overlap: req_ready_o is low from accept until the response handshake completes.
  - A new request can be accepted in the cycle after the rsp handshake (IDLE).
  - req_valid_i asserted while not ready is held off; no input is sampled.
- rsp_ready_i held high in RESP: one cycle valid, then IDLE.
- Inputs are ignored outside IDLE; changes after accept have no effect.

Decomposition:
- Package lsu_pkg:
  - typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL}.
  - State enum {S_IDLE, S_ACCESS, S_RESP}.
  - Function size_to_nbytes.
- One natural sub-module: lsu_load_extend. Combinational; takes acc, size and unsigned, and produces the 32-bit extended result.
- FSM, counter and byte mux stay in the top.

Test Plan:
- LW at 0x100, RAM[0x100..0x103]=12,34,56,78 -> 4 byte reads at 0x100..0x103; rsp_rdata_o=0x12345678 at N+5; rsp_err_o=0.
- LB at 0x20 (RAM=0x80) -> rsp_rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x21 (RAM 0x81,0x02) -> 0xFFFF8102.
- SW 0xDEADBEEF at 0x40 -> mem_we_o high exactly 4 cycles; RAM 0x40..0x43 = DE,AD,BE,EF. SH 0xCAFE at 0x43 -> RAM 0x43=CA, 0x44=FE; rsp_rdata_o=0.
- req_size_i=3 -> no mem_we_o pulse, no address activity; rsp_valid_o at N+1 with rsp_err_o=1; rsp_ready_i held low 3 cycles -> response held stable.
- LW at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1 in order.
- SW in progress, rst_ni low after the 2nd byte -> outputs 0 immediately, bytes 3-4 never written; after release req_ready_o=1.
